nn_neuron_mac: RTL and testbench
================================

Name: nn_neuron_mac

Overview:
- Downstream consumer of the 8-deep, 32-bit input FIFO in the wishbone NN datapath.
- Pops packed {weight, activation} words from the FIFO and multiply-accumulates N_INPUTS pairs onto a bias.
- Applies an optional ReLU and saturates to 16-bit Q8.8.
- Presents the neuron result on a valid/ready output toward the result/readback logic.

Parameters:
- N_INPUTS, 8, number of weight/activation pairs per neuron evaluation (1..255).
- ACC_W, 40, signed accumulator width in bits (must be >= 32 + clog2(N_INPUTS) + 1).
- FRAC, 8, fractional bits of the Q8.8 operand format.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse; begins an evaluation; ignored unless in IDLE.
- bias  input  16  signed Q8.8 bias; sampled on accepted start.
- relu_en  input  1  ReLU enable; sampled on accepted start.
- fifo_empty  input  1  high when the FIFO holds no words.
- fifo_rd  output  1  pop request; FIFO data is valid on fifo_data in the following cycle.
- fifo_data  input  32  [31:16] signed Q8.8 weight, [15:0] signed Q8.8 activation.
- busy  output  1  high in every state except IDLE.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  16  signed Q8.8 result, registered.
- out_sat  output  1  high if saturation occurred; valid alongside out_valid.

Behaviour:
- Reset (async assert): state IDLE; acc=0, cnt=0; fifo_rd=0, busy=0, out_valid=0, out_data=0, out_sat=0, latched relu=0. Reset mid-evaluation abandons it, with no further pops.
- IDLE:
  - On start: acc <= sign_ext(bias) << FRAC; cnt <= 0; latch relu_en; go to FETCH.
- FETCH:
  - fifo_rd = !fifo_empty, combinational from state and fifo_empty.
  - If a word is popped, go to WAIT; otherwise stay in FETCH (stall indefinitely).
- WAIT (fifo_data valid this cycle):
  - acc <= acc + sign_ext(w*a), where w*a is a 32-bit signed Q16.16 product.
  - cnt <= cnt + 1.
  - If cnt == N_INPUTS-1, go to ACT; else go to FETCH.
- ACT:
  - r = acc >>> FRAC (arithmetic shift, truncates toward −inf).
  - If latched relu and r < 0: r = 0.
  - If r > 32767: out_data=0x7FFF, out_sat=1.
  - Else if r < −32768: out_data=0x8000, out_sat=1.
  - Else: out_data=r[15:0], out_sat=0.
  - Go to DONE.
- DONE:
  - out_valid=1; out_data and out_sat held stable.
  - When out_valid && out_ready: return to IDLE, and out_valid deasserts next cycle.
  - out_data keeps its last value after the handshake.
- Throughput and latency:
  - Throughput is 2 cycles per pair with no stalls.
  - Start to out_valid is 2·N_INPUTS+2 cycles when the FIFO never runs empty.
- Boundary rules:
  - start while busy is ignored; no state change.
  - Exactly N_INPUTS pops per evaluation; never a pop in IDLE, WAIT, ACT or DONE.
  - The block never pops while fifo_empty=1.
  - The accumulator never wraps within the parameter constraint above.
  - fifo_data is sampled only in WAIT.

Test Plan:
1. bias=0x0000, relu_en=0, 8 words w=0x0100 a=0x0200 preloaded -> out_data=0x1000, out_sat=0, out_valid at start+18 cycles, exactly 8 fifo_rd pulses.
2. bias=0xFF00, 8 words w=0x0100 a=0xFF00 -> relu_en=0 gives out_data=0xF700; rerun with relu_en=1 gives 0x0000; out_sat=0 in both.
3. 8 words w=0x7FFF a=0x7FFF, bias=0x7FFF -> out_data=0x7FFF, out_sat=1; with a=0x8000 instead -> out_data=0x8000, out_sat=1.
4. Case 1 words fed with fifo_empty high for 3 cycles between each word -> fifo_rd never asserted while empty, result still 0x1000.
5. out_ready held low 6 cycles after out_valid, plus a start pulse during DONE -> out_valid and out_data stable, start ignored, IDLE one cycle after ready.
6. rst asserted asynchronously mid-cycle after 3 pairs -> busy, fifo_rd and out_valid drop immediately; a new start with case 1 data gives 0x1000 (no residue).

Source files
------------

// File: rtl/nn_neuron_mac.sv
// Neuron multiply-accumulate engine: pops packed {weight, activation} Q8.8 words
// from the input FIFO, accumulates them onto a bias, then applies ReLU and Q8.8 saturation.
module nn_neuron_mac #(
  parameter int N_INPUTS = 8,
  parameter int ACC_W    = 40,
  parameter int FRAC     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bias,
  input  logic        relu_en,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  input  logic [31:0] fifo_data,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sat
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ACT   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [7:0]              LAST_IDX = 8'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] R_MAX    = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] R_MIN    = ~R_MAX;

  logic [2:0]              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    relu_q, relu_d;
  logic [15:0]             out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] shifted;
  logic signed [31:0]      w_ext;
  logic signed [31:0]      a_ext;
  logic signed [31:0]      prod;
  logic [15:0]             sat_data;
  logic                    sat_flag;

  assign fifo_rd   = (state_q == S_FETCH) && !fifo_empty;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // Q8.8 x Q8.8 gives a Q16.16 product; the accumulator keeps 16 fractional bits throughout.
  always_comb begin
    bias_ext = {{(ACC_W-16){bias[15]}}, bias};
    w_ext    = {{16{fifo_data[31]}}, fifo_data[31:16]};
    a_ext    = {{16{fifo_data[15]}}, fifo_data[15:0]};
    prod     = w_ext * a_ext;
    prod_ext = {{(ACC_W-32){prod[31]}}, prod};

    shifted = acc_q >>> FRAC;
    if (relu_q && shifted[ACC_W-1]) begin
      shifted = '0;
    end

    if (shifted > R_MAX) begin
      sat_data = 16'h7FFF;
      sat_flag = 1'b1;
    end else if (shifted < R_MIN) begin
      sat_data = 16'h8000;
      sat_flag = 1'b1;
    end else begin
      sat_data = shifted[15:0];
      sat_flag = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    relu_d     = relu_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = bias_ext <<< FRAC;
          cnt_d   = '0;
          relu_d  = relu_en;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (fifo_rd) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        acc_d   = acc_q + prod_ext;
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_q == LAST_IDX) ? S_ACT : S_FETCH;
      end
      S_ACT: begin
        out_data_d = sat_data;
        out_sat_d  = sat_flag;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      relu_q     <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      relu_q     <= relu_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_nn_neuron_mac.sv
// Self-checking bench for nn_neuron_mac: behavioural FIFO plus an arithmetic reference
// model of the neuron (weighted sum, floor shift, ReLU, Q8.8 saturation).
module tb_nn_neuron_mac;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bias;
  logic        relu_en;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [31:0] fifo_data = '0;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] fifo_mem [0:1023];
  int rd_ptr    = 0;
  int wr_ptr    = 0;
  int gap       = 0;
  int stall_cnt = 0;
  int pop_count = 0;
  int bad_pops  = 0;
  logic [31:0] exp_words [$];

  nn_neuron_mac #(.N_INPUTS(N), .ACC_W(40), .FRAC(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .relu_en(relu_en),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_data(fifo_data),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears on fifo_data the cycle after a pop; an optional gap forces empty after each pop.
  assign fifo_empty = (stall_cnt != 0) || (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd) begin
      if (fifo_empty) bad_pops <= bad_pops + 1;
      fifo_data <= fifo_mem[rd_ptr % 1024];
      if (rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
      pop_count <= pop_count + 1;
      stall_cnt <= gap;
    end else if (stall_cnt != 0) begin
      stall_cnt <= stall_cnt - 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model(input logic [15:0] b, input bit r,
                                output logic [15:0] d, output bit s);
    longint sum;
    longint res;
    sum = longint'($signed(b)) * 256;
    for (int i = 0; i < N; i++) begin
      sum += longint'($signed(exp_words[i][31:16])) * longint'($signed(exp_words[i][15:0]));
    end
    res = sum >>> 8;
    if (r && res < 0) res = 0;
    if (res > 32767) begin
      d = 16'h7FFF; s = 1'b1;
    end else if (res < -32768) begin
      d = 16'h8000; s = 1'b1;
    end else begin
      d = 16'(res); s = 1'b0;
    end
  endfunction

  task automatic flush_fifo();
    @(negedge clk);
    wr_ptr = rd_ptr;
    exp_words.delete();
  endtask

  task automatic push_word(input logic [31:0] wd);
    fifo_mem[wr_ptr % 1024] = wd;
    wr_ptr = wr_ptr + 1;
    exp_words.push_back(wd);
  endtask

  task automatic load_case(input logic [15:0] w, input logic [15:0] a);
    flush_fifo();
    for (int i = 0; i < N; i++) push_word({w, a});
  endtask

  task automatic run_neuron(input logic [15:0] b, input bit r,
                            output int cycles, output int pops, output bit timed_out);
    int p0;
    p0 = pop_count;
    @(negedge clk);
    bias = b; relu_en = r; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; bias = 16'($urandom); relu_en = ~r;
    cycles = 1;
    while (!out_valid && cycles < 3000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    timed_out = !out_valid;
    pops = pop_count - p0;
    relu_en = 1'b0;
  endtask

  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (fifo_rd !== 1'b0) $display("FAIL reset_fifo_rd: got %b want 0", fifo_rd); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'h0000) $display("FAIL reset_out_data: got %h want 0000", out_data); else n_pass++;
    n_checks++; if (out_sat !== 1'b0) $display("FAIL reset_out_sat: got %b want 0", out_sat); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc, pops; bit to; logic [15:0] ed; bit es;
    load_case(16'h0100, 16'h0200);
    model(16'h0000, 1'b0, ed, es);
    run_neuron(16'h0000, 1'b0, cyc, pops, to);
    n_checks++; if (to !== 1'b0) $display("FAIL basic_timeout: out_valid never rose"); else n_pass++;
    n_checks++; if (out_data !== ed || ed !== 16'h1000) $display("FAIL basic_data: got %h want %h", out_data, ed); else n_pass++;
    n_checks++; if (out_sat !== es) $display("FAIL basic_sat: got %b want %b", out_sat, es); else n_pass++;
    n_checks++; if (cyc !== 2*N+2) $display("FAIL basic_latency: got %0d want %0d", cyc, 2*N+2); else n_pass++;
    n_checks++; if (pops !== N) $display("FAIL basic_pops: got %0d want %0d", pops, N); else n_pass++;
    accept();
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL basic_idle: valid %b busy %b want 0 0", out_valid, busy); else n_pass++;
  endtask

  task automatic test_relu();
    int cyc, pops; bit to; logic [15:0] ed; bit es;
    for (int r = 0; r < 2; r++) begin
      load_case(16'h0100, 16'hFF00);
      model(16'hFF00, r[0], ed, es);
      run_neuron(16'hFF00, r[0], cyc, pops, to);
      n_checks++; if (to !== 1'b0) $display("FAIL relu%0d_timeout: out_valid never rose", r); else n_pass++;
      n_checks++; if (out_data !== ed || ed !== (r == 0 ? 16'hF700 : 16'h0000)) $display("FAIL relu%0d_data: got %h want %h", r, out_data, ed); else n_pass++;
      n_checks++; if (out_sat !== 1'b0) $display("FAIL relu%0d_sat: got %b want 0", r, out_sat); else n_pass++;
      accept();
    end
  endtask

  task automatic test_saturation();
    int cyc, pops; bit to; logic [15:0] ed; bit es;
    logic [15:0] acts [2];
    acts[0] = 16'h7FFF; acts[1] = 16'h8000;
    for (int k = 0; k < 2; k++) begin
      load_case(16'h7FFF, acts[k]);
      model(16'h7FFF, 1'b0, ed, es);
      run_neuron(16'h7FFF, 1'b0, cyc, pops, to);
      n_checks++; if (to !== 1'b0) $display("FAIL sat%0d_timeout: out_valid never rose", k); else n_pass++;
      n_checks++; if (out_data !== ed || ed !== (k == 0 ? 16'h7FFF : 16'h8000)) $display("FAIL sat%0d_data: got %h want %h", k, out_data, ed); else n_pass++;
      n_checks++; if (out_sat !== 1'b1) $display("FAIL sat%0d_flag: got %b want 1", k, out_sat); else n_pass++;
      accept();
    end
  endtask

  task automatic test_stall();
    int cyc, pops, bad0; bit to;
    bad0 = bad_pops;
    load_case(16'h0100, 16'h0200);
    gap = 3;
    run_neuron(16'h0000, 1'b0, cyc, pops, to);
    gap = 0;
    n_checks++; if (to !== 1'b0) $display("FAIL stall_timeout: out_valid never rose"); else n_pass++;
    n_checks++; if (out_data !== 16'h1000) $display("FAIL stall_data: got %h want 1000", out_data); else n_pass++;
    n_checks++; if (bad_pops !== bad0) $display("FAIL stall_pop_while_empty: got %0d want %0d", bad_pops, bad0); else n_pass++;
    n_checks++; if (pops !== N) $display("FAIL stall_pops: got %0d want %0d", pops, N); else n_pass++;
    n_checks++; if (cyc <= 2*N+2) $display("FAIL stall_latency: got %0d want more than %0d", cyc, 2*N+2); else n_pass++;
    accept();
  endtask

  task automatic test_backpressure();
    int cyc, pops, p0; bit to;
    load_case(16'h0100, 16'h0200);
    run_neuron(16'h0000, 1'b0, cyc, pops, to);
    n_checks++; if (to !== 1'b0) $display("FAIL bp_timeout: out_valid never rose"); else n_pass++;
    @(negedge clk);
    push_word(32'h0100_0100);
    p0 = pop_count;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = (i == 2);
      bias = 16'h4000;
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h1000 || out_sat !== 1'b0)
        $display("FAIL bp_hold%0d: valid %b data %h sat %b want 1 1000 0", i, out_valid, out_data, out_sat);
      else n_pass++;
    end
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (pop_count !== p0) $display("FAIL bp_start_ignored: pops %0d want %0d", pop_count, p0); else n_pass++;
    accept();
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_idle: valid %b busy %b want 0 0", out_valid, busy); else n_pass++;
    n_checks++; if (out_data !== 16'h1000) $display("FAIL bp_data_kept: got %h want 1000", out_data); else n_pass++;
  endtask

  task automatic test_mid_reset();
    int cyc, pops, p0, waited; bit to;
    load_case(16'h0100, 16'h0200);
    p0 = pop_count;
    @(negedge clk);
    bias = 16'h0300; relu_en = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waited = 0;
    while (pop_count - p0 < 3 && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    n_checks++; if (pop_count - p0 !== 3) $display("FAIL mrst_progress: pops %0d want 3", pop_count - p0); else n_pass++;
    @(posedge clk);
    #2;
    n_checks++; if (fifo_rd !== 1'b1 || busy !== 1'b1) $display("FAIL mrst_pre: fifo_rd %b busy %b want 1 1", fifo_rd, busy); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || fifo_rd !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL mrst_async: busy %b fifo_rd %b valid %b want 0 0 0", busy, fifo_rd, out_valid);
    else n_pass++;
    p0 = pop_count;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (pop_count !== p0) $display("FAIL mrst_no_pops: pops %0d want %0d", pop_count, p0); else n_pass++;
    load_case(16'h0100, 16'h0200);
    run_neuron(16'h0000, 1'b0, cyc, pops, to);
    n_checks++; if (to !== 1'b0 || out_data !== 16'h1000) $display("FAIL mrst_rerun: timeout %b data %h want 0 1000", to, out_data); else n_pass++;
    n_checks++; if (pops !== N) $display("FAIL mrst_rerun_pops: got %0d want %0d", pops, N); else n_pass++;
    accept();
  endtask

  task automatic test_random();
    int cyc, pops, bad0; bit to; logic [15:0] ed; bit es;
    logic [15:0] b, w, a; bit r;
    for (int it = 0; it < 6; it++) begin
      flush_fifo();
      for (int i = 0; i < N; i++) begin
        if (it < 4) begin
          w = 16'($urandom_range(0, 2047)) - 16'd1024;
          a = 16'($urandom_range(0, 2047)) - 16'd1024;
        end else begin
          w = 16'($urandom);
          a = 16'($urandom);
        end
        push_word({w, a});
      end
      b = (it < 4) ? 16'($urandom_range(0, 4095)) - 16'd2048 : 16'($urandom);
      r = 1'($urandom);
      gap = $urandom_range(0, 2);
      bad0 = bad_pops;
      model(b, r, ed, es);
      run_neuron(b, r, cyc, pops, to);
      gap = 0;
      n_checks++; if (to !== 1'b0) $display("FAIL rand%0d_timeout: out_valid never rose", it); else n_pass++;
      n_checks++; if (out_data !== ed || out_sat !== es)
        $display("FAIL rand%0d_result: got %h/%b want %h/%b", it, out_data, out_sat, ed, es);
      else n_pass++;
      n_checks++; if (pops !== N || bad_pops !== bad0) $display("FAIL rand%0d_pops: got %0d bad %0d want %0d bad %0d", it, pops, bad_pops, N, bad0); else n_pass++;
      accept();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bias = '0; relu_en = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_stall();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
